// File: rtl/pll_reconfig_seq.sv
// Run-time reconfiguration sequencer for the fractional PLL: writes mode/N/M/K/C0 through
// the Avalon-MM reconfig port, starts it, then waits for re-lock with reset-and-retry recovery.
module pll_reconfig_seq #(
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_STABLE  = 16,
    parameter int RST_CYCLES   = 32,
    parameter int MAX_RETRIES  = 3
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [17:0] cfg_c0,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        pll_rst
);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int ST_W = $clog2(LOCK_STABLE + 2);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int RT_W = $clog2(MAX_RETRIES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_K, S_WR_C0, S_WR_START,
        S_WAIT_LOCK, S_PLL_RESET, S_DONE_OK, S_DONE_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_lk_meta;
    logic              r_lk_s;
    logic [TO_W-1:0]   r_timeout;
    logic [ST_W-1:0]   r_stable;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [RT_W-1:0]   r_retries;
    logic              r_err;
    logic [17:0]       r_n;
    logic [17:0]       r_m;
    logic [31:0]       r_k;
    logic [17:0]       r_c0;

    logic w_accept;
    logic w_stable_hit;
    logic w_timeout_hit;
    logic w_retry_ok;
    logic w_rst_last;

    assign w_accept      = (r_state == S_IDLE) && cfg_req;
    assign w_stable_hit  = (r_stable == ST_W'(LOCK_STABLE));
    assign w_timeout_hit = (r_timeout == TO_W'(LOCK_TIMEOUT - 1));
    assign w_retry_ok    = (r_retries < RT_W'(MAX_RETRIES));
    assign w_rst_last    = (r_rst_cnt == RC_W'(RST_CYCLES - 1));

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lk_meta <= pll_locked;
            r_lk_s    <= r_lk_meta;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (cfg_req) w_state_nxt = S_WR_MODE;
            S_WR_MODE:   if (!mgmt_waitrequest) w_state_nxt = S_WR_N;
            S_WR_N:      if (!mgmt_waitrequest) w_state_nxt = S_WR_M;
            S_WR_M:      if (!mgmt_waitrequest) w_state_nxt = S_WR_K;
            S_WR_K:      if (!mgmt_waitrequest) w_state_nxt = S_WR_C0;
            S_WR_C0:     if (!mgmt_waitrequest) w_state_nxt = S_WR_START;
            S_WR_START:  if (!mgmt_waitrequest) w_state_nxt = S_WAIT_LOCK;
            // A lock that qualifies in the same cycle as the timeout wins.
            S_WAIT_LOCK: begin
                if (w_stable_hit)
                    w_state_nxt = S_DONE_OK;
                else if (w_timeout_hit)
                    w_state_nxt = w_retry_ok ? S_PLL_RESET : S_DONE_ERR;
            end
            S_PLL_RESET: if (w_rst_last) w_state_nxt = S_WAIT_LOCK;
            S_DONE_OK:   w_state_nxt = S_IDLE;
            S_DONE_ERR:  w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_timeout <= '0;
            r_stable  <= '0;
            r_rst_cnt <= '0;
            r_retries <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_WAIT_LOCK) begin
                r_timeout <= r_timeout + TO_W'(1);
                r_stable  <= r_lk_s ? r_stable + ST_W'(1) : '0;
            end else begin
                r_timeout <= '0;
                r_stable  <= '0;
            end
            r_rst_cnt <= (r_state == S_PLL_RESET) ? r_rst_cnt + RC_W'(1) : '0;
            if (w_accept) begin
                r_retries <= '0;
                r_err     <= 1'b0;
            end else if (r_state == S_WAIT_LOCK && w_state_nxt == S_PLL_RESET) begin
                r_retries <= r_retries + RT_W'(1);
            end else if (r_state == S_WAIT_LOCK && w_state_nxt == S_DONE_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    // Configuration words are plain data captured at accept; no reset needed.
    always_ff @(posedge refclk) begin
        if (w_accept) begin
            r_n  <= cfg_n;
            r_m  <= cfg_m;
            r_k  <= cfg_k;
            r_c0 <= cfg_c0;
        end
    end

    always_comb begin
        mgmt_write     = 1'b0;
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h0;
        pll_rst        = 1'b0;
        cfg_done       = 1'b0;
        cfg_busy       = (r_state != S_IDLE);
        cfg_err        = r_err;
        case (r_state)
            S_WR_MODE: begin
                mgmt_write = 1'b1;
            end
            S_WR_N: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h03;
                mgmt_writedata = {14'b0, r_n};
            end
            S_WR_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h04;
                mgmt_writedata = {14'b0, r_m};
            end
            S_WR_K: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h07;
                mgmt_writedata = r_k;
            end
            // Counter select in [22:18] stays 0 to address C0.
            S_WR_C0: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'h05;
                mgmt_writedata = {9'b0, 5'd0, r_c0};
            end
            S_WR_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = 6'h02;
            end
            S_PLL_RESET: pll_rst  = 1'b1;
            S_DONE_OK:   cfg_done = 1'b1;
            S_DONE_ERR:  cfg_done = 1'b1;
            default: ;
        endcase
    end
endmodule
